// File: rtl/race_sequencer_if.sv
// Game-flow signal bundle between the race sequencer (slave) and the board/peer logic (master).
interface race_sequencer_if;
  logic        start_pulse;
  logic        pause_pulse;
  logic        p1_finish;
  logic        p2_finish;
  logic        peer_ready;
  logic [2:0]  state;
  logic [3:0]  countdown;
  logic [13:0] race_time;
  logic [1:0]  winner;
  logic        sync_req;
  logic        state_chg;

  modport master (
    output start_pulse, pause_pulse, p1_finish, p2_finish, peer_ready,
    input  state, countdown, race_time, winner, sync_req, state_chg
  );

  modport slave (
    input  start_pulse, pause_pulse, p1_finish, p2_finish, peer_ready,
    output state, countdown, race_time, winner, sync_req, state_chg
  );
endinterface

// File: rtl/race_sequencer.sv
// Two-player racer game-flow controller: countdown, race timer, pause and winner detection.
// Define RACE_SYNC_HANDSHAKE_EN to add the SYNCING peer handshake before the countdown.
module race_sequencer #(
  parameter int unsigned CLK_FREQ       = 100_000_000,
  parameter int unsigned COUNT_SECONDS  = 3,
  parameter int unsigned CS_DIV         = CLK_FREQ / 100,
  parameter int unsigned MAX_TIME       = 9999,
  parameter int unsigned SYNC_TIMEOUT_S = 5
) (
  input logic              clk,
  input logic              rst,
  race_sequencer_if.slave  bus
);

  localparam int unsigned SEC_W = $clog2(CLK_FREQ + 1);
  localparam int unsigned CS_W  = $clog2(CS_DIV + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SETTING   = 3'd1,
    S_SYNCING   = 3'd2,
    S_COUNTDOWN = 3'd3,
    S_RACING    = 3'd4,
    S_PAUSE     = 3'd5,
    S_FINISH    = 3'd6
  } state_t;

  state_t           st;
  logic [SEC_W-1:0] sec_cnt;
  logic [CS_W-1:0]  cs_cnt;
  logic [3:0]       countdown_q;
  logic [13:0]      race_time_q;
  logic [1:0]       winner_q;
  logic             state_chg_q;
  logic             sec_wrap;
  logic             cs_wrap;

  assign sec_wrap = (sec_cnt == SEC_W'(CLK_FREQ - 1));
  assign cs_wrap  = (cs_cnt == CS_W'(CS_DIV - 1));

`ifdef RACE_SYNC_HANDSHAKE_EN
  localparam int unsigned TO_W = $clog2(SYNC_TIMEOUT_S + 1);
  logic [TO_W-1:0] sync_sec;
  logic            sync_req_q;
  assign bus.sync_req = sync_req_q;
`else
  logic unused_peer_ready;
  assign unused_peer_ready = bus.peer_ready;
  assign bus.sync_req      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      st          <= S_IDLE;
      sec_cnt     <= '0;
      cs_cnt      <= '0;
      countdown_q <= '0;
      race_time_q <= '0;
      winner_q    <= '0;
      state_chg_q <= 1'b0;
`ifdef RACE_SYNC_HANDSHAKE_EN
      sync_sec    <= '0;
      sync_req_q  <= 1'b0;
`endif
    end else begin
      state_chg_q <= 1'b0;
`ifdef RACE_SYNC_HANDSHAKE_EN
      sync_req_q  <= 1'b0;
`endif
      case (st)
        S_IDLE: begin
          race_time_q <= '0;
          winner_q    <= '0;
          if (bus.start_pulse) begin
            st          <= S_SETTING;
            state_chg_q <= 1'b1;
          end
        end
        S_SETTING: begin
          if (bus.start_pulse) begin
            state_chg_q <= 1'b1;
            sec_cnt     <= '0;
`ifdef RACE_SYNC_HANDSHAKE_EN
            st          <= S_SYNCING;
            sync_sec    <= '0;
            sync_req_q  <= 1'b1;
`else
            st          <= S_COUNTDOWN;
            countdown_q <= 4'(COUNT_SECONDS);
`endif
          end
        end
`ifdef RACE_SYNC_HANDSHAKE_EN
        S_SYNCING: begin
          if (bus.start_pulse) begin
            st          <= S_SETTING;
            state_chg_q <= 1'b1;
          end else if (bus.peer_ready) begin
            st          <= S_COUNTDOWN;
            state_chg_q <= 1'b1;
            countdown_q <= 4'(COUNT_SECONDS);
            sec_cnt     <= '0;
          end else if (sec_wrap && sync_sec == TO_W'(SYNC_TIMEOUT_S - 1)) begin
            st          <= S_SETTING;
            state_chg_q <= 1'b1;
          end else begin
            sync_req_q <= 1'b1;
            if (sec_wrap) begin
              sec_cnt  <= '0;
              sync_sec <= sync_sec + 1'b1;
            end else begin
              sec_cnt <= sec_cnt + 1'b1;
            end
          end
        end
`endif
        S_COUNTDOWN: begin
          if (sec_wrap) begin
            sec_cnt     <= '0;
            countdown_q <= countdown_q - 4'd1;
            if (countdown_q == 4'd1) begin
              st          <= S_RACING;
              state_chg_q <= 1'b1;
              cs_cnt      <= '0;
            end
          end else begin
            sec_cnt <= sec_cnt + 1'b1;
          end
        end
        S_RACING: begin
          // Leaving RACING freezes the timer in that same cycle, so PAUSE resumes exactly where it stopped.
          if (bus.p1_finish || bus.p2_finish) begin
            st          <= S_FINISH;
            state_chg_q <= 1'b1;
            winner_q    <= {bus.p2_finish, bus.p1_finish};
          end else if (bus.pause_pulse) begin
            st          <= S_PAUSE;
            state_chg_q <= 1'b1;
          end else if (cs_wrap) begin
            cs_cnt <= '0;
            if (race_time_q < 14'(MAX_TIME)) begin
              race_time_q <= race_time_q + 14'd1;
            end
          end else begin
            cs_cnt <= cs_cnt + 1'b1;
          end
        end
        S_PAUSE: begin
          if (bus.pause_pulse) begin
            st          <= S_RACING;
            state_chg_q <= 1'b1;
          end else if (bus.start_pulse) begin
            st          <= S_IDLE;
            state_chg_q <= 1'b1;
            race_time_q <= '0;
            winner_q    <= '0;
          end
        end
        S_FINISH: begin
          if (bus.start_pulse) begin
            st          <= S_IDLE;
            state_chg_q <= 1'b1;
            race_time_q <= '0;
            winner_q    <= '0;
          end
        end
        default: begin
          st          <= S_IDLE;
          state_chg_q <= 1'b1;
          countdown_q <= '0;
          race_time_q <= '0;
          winner_q    <= '0;
        end
      endcase
    end
  end

  assign bus.state     = st;
  assign bus.countdown = countdown_q;
  assign bus.race_time = race_time_q;
  assign bus.winner    = winner_q;
  assign bus.state_chg = state_chg_q;

endmodule

// File: tb/tb_race_sequencer.sv
// Self-checking bench for race_sequencer: vector table through a scoreboard, then hand-written reset/timing sequences.
module tb_race_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  race_sequencer_if bus();
  race_sequencer_if bus_sat();

  assign bus_sat.start_pulse = bus.start_pulse;
  assign bus_sat.pause_pulse = bus.pause_pulse;
  assign bus_sat.p1_finish   = bus.p1_finish;
  assign bus_sat.p2_finish   = bus.p2_finish;
  assign bus_sat.peer_ready  = bus.peer_ready;

  race_sequencer #(.CLK_FREQ(1000), .COUNT_SECONDS(3), .CS_DIV(10), .MAX_TIME(9999), .SYNC_TIMEOUT_S(5))
    dut (.clk(clk), .rst(rst), .bus(bus));

  race_sequencer #(.CLK_FREQ(1000), .COUNT_SECONDS(3), .CS_DIV(10), .MAX_TIME(30), .SYNC_TIMEOUT_S(5))
    dut_sat (.clk(clk), .rst(rst), .bus(bus_sat));

  localparam logic [5:0] I_NONE = 6'b000000;
  localparam logic [5:0] I_RST  = 6'b100000;
  localparam logic [5:0] I_ST   = 6'b010000;
  localparam logic [5:0] I_PA   = 6'b001000;
  localparam logic [5:0] I_P1   = 6'b000100;
  localparam logic [5:0] I_P2   = 6'b000010;
  localparam logic [5:0] I_PR   = 6'b000001;

  typedef struct {
    int         pre;
    logic [5:0] in;
    int         st, cd, rt, w, chg, sy, sat;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic add(input int pre, input logic [5:0] in, input int st, input int cd,
                     input int rt, input int w, input int chg, input int sy);
    vec_t v;
    v.pre = pre; v.in = in; v.st = st; v.cd = cd; v.rt = rt; v.w = w;
    v.chg = chg; v.sy = sy; v.sat = (rt < 30) ? rt : 30;
    vecs.push_back(v);
  endtask

  // From SETTING into COUNTDOWN, through SYNCING when the handshake is built in.
  task automatic add_cd_entry();
`ifdef RACE_SYNC_HANDSHAKE_EN
    add(0, I_ST, 2, 0, 0, 0, 1, 1);
    add(0, I_PR, 3, 3, 0, 0, 1, 0);
`else
    add(0, I_ST, 3, 3, 0, 0, 1, 0);
`endif
  endtask

  task automatic tick(input logic [5:0] in);
    @(negedge clk);
    rst             = in[5];
    bus.start_pulse = in[4];
    bus.pause_pulse = in[3];
    bus.p1_finish   = in[2];
    bus.p2_finish   = in[1];
    bus.peer_ready  = in[0];
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(I_NONE);
  endtask

  task automatic go_countdown();
    tick(I_ST);
`ifdef RACE_SYNC_HANDSHAKE_EN
    tick(I_PR);
`endif
    chk("hs.cd_entry_state", int'(bus.state), 3);
    chk("hs.cd_entry_count", int'(bus.countdown), 3);
  endtask

  task automatic wait_state(input int target, input int budget, output int n);
    n = 0;
    while (n < budget && int'(bus.state) != target) begin
      tick(I_NONE);
      n++;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".state"}, int'(bus.state), 0);
    chk({tag, ".countdown"}, int'(bus.countdown), 0);
    chk({tag, ".race_time"}, int'(bus.race_time), 0);
    chk({tag, ".winner"}, int'(bus.winner), 0);
    chk({tag, ".sync_req"}, int'(bus.sync_req), 0);
    chk({tag, ".state_chg"}, int'(bus.state_chg), 0);
  endtask

  initial begin
    vec_t e;
    int   n;
    bus.start_pulse = 1'b0; bus.pause_pulse = 1'b0;
    bus.p1_finish = 1'b0; bus.p2_finish = 1'b0; bus.peer_ready = 1'b0;

    // Race A: countdown timing, timer rate, p2 win, finish hold
    add(0,   I_RST,  0, 0, 0,  0, 0, 0);
    add(2,   I_NONE, 0, 0, 0,  0, 0, 0);
    add(0,   I_ST,   1, 0, 0,  0, 1, 0);
    add_cd_entry();
    add(0,   I_NONE, 3, 3, 0,  0, 0, 0);
    add(997, I_NONE, 3, 3, 0,  0, 0, 0);
    add(0,   I_NONE, 3, 2, 0,  0, 0, 0);
    add(998, I_NONE, 3, 2, 0,  0, 0, 0);
    add(0,   I_NONE, 3, 1, 0,  0, 0, 0);
    add(998, I_NONE, 3, 1, 0,  0, 0, 0);
    add(0,   I_NONE, 4, 0, 0,  0, 1, 0);
    add(8,   I_NONE, 4, 0, 0,  0, 0, 0);
    add(0,   I_NONE, 4, 0, 1,  0, 0, 0);
    add(488, I_NONE, 4, 0, 49, 0, 0, 0);
    add(0,   I_NONE, 4, 0, 50, 0, 0, 0);
    add(0,   I_P2,   6, 0, 50, 2, 1, 0);
    add(18,  I_NONE, 6, 0, 50, 2, 0, 0);
    add(0,   I_P1,   6, 0, 50, 2, 0, 0);
    add(0,   I_ST,   0, 0, 0,  0, 1, 0);
    // Race B: start ignored while racing, pause freeze/resume, pause beats start, abort
    add(0,   I_ST,   1, 0, 0,  0, 1, 0);
    add_cd_entry();
    add(2998, I_NONE, 3, 1, 0, 0, 0, 0);
    add(0,   I_NONE, 4, 0, 0,  0, 1, 0);
    add(198, I_NONE, 4, 0, 19, 0, 0, 0);
    add(0,   I_ST,   4, 0, 20, 0, 0, 0);
    add(0,   I_PA,   5, 0, 20, 0, 1, 0);
    add(0,   I_P1,   5, 0, 20, 0, 0, 0);
    add(998, I_NONE, 5, 0, 20, 0, 0, 0);
    add(0,   I_PA,   4, 0, 20, 0, 1, 0);
    add(8,   I_NONE, 4, 0, 20, 0, 0, 0);
    add(0,   I_NONE, 4, 0, 21, 0, 0, 0);
    add(0,   I_PA,   5, 0, 21, 0, 1, 0);
    add(0,   I_ST | I_PA, 4, 0, 21, 0, 1, 0);
    add(0,   I_PA,   5, 0, 21, 0, 1, 0);
    add(0,   I_ST,   0, 0, 0,  0, 1, 0);
    // Race C: tie with simultaneous pause
    add(0,   I_ST,   1, 0, 0,  0, 1, 0);
    add_cd_entry();
    add(2998, I_NONE, 3, 1, 0, 0, 0, 0);
    add(0,   I_NONE, 4, 0, 0,  0, 1, 0);
    add(49,  I_NONE, 4, 0, 5,  0, 0, 0);
    add(0,   I_P1 | I_P2 | I_PA, 6, 0, 5, 3, 1, 0);
    add(0,   I_PA,   6, 0, 5,  3, 0, 0);
    add(0,   I_ST,   0, 0, 0,  0, 1, 0);
`ifdef RACE_SYNC_HANDSHAKE_EN
    // Handshake: timeout back to SETTING, cancel, then peer_ready
    add(0,    I_ST,   1, 0, 0, 0, 1, 0);
    add(0,    I_ST,   2, 0, 0, 0, 1, 1);
    add(0,    I_NONE, 2, 0, 0, 0, 0, 1);
    add(4997, I_NONE, 2, 0, 0, 0, 0, 1);
    add(0,    I_NONE, 1, 0, 0, 0, 1, 0);
    add(0,    I_ST,   2, 0, 0, 0, 1, 1);
    add(0,    I_ST,   1, 0, 0, 0, 1, 0);
    add(0,    I_ST,   2, 0, 0, 0, 1, 1);
    add(0,    I_PR,   3, 3, 0, 0, 1, 0);
    add(0,    I_RST,  0, 0, 0, 0, 0, 0);
`endif

    foreach (vecs[i]) begin
      idle(vecs[i].pre);
      tick(vecs[i].in);
      exp_q.push_back(vecs[i]);
      e = exp_q.pop_front();
      chk($sformatf("v%0d.state", i),     int'(bus.state),         e.st);
      chk($sformatf("v%0d.countdown", i), int'(bus.countdown),     e.cd);
      chk($sformatf("v%0d.race_time", i), int'(bus.race_time),     e.rt);
      chk($sformatf("v%0d.winner", i),    int'(bus.winner),        e.w);
      chk($sformatf("v%0d.state_chg", i), int'(bus.state_chg),     e.chg);
      chk($sformatf("v%0d.sync_req", i),  int'(bus.sync_req),      e.sy);
      chk($sformatf("v%0d.sat_time", i),  int'(bus_sat.race_time), e.sat);
    end

    // Reset mid-countdown
    tick(I_ST);
    chk("hs.setting", int'(bus.state), 1);
    go_countdown();
    n = 0;
    while (n < 2000 && bus.countdown != 4'd2) begin
      tick(I_NONE);
      n++;
    end
    chk("hs.cd2_cycles", n, 1000);
    tick(I_RST);
    chk_reset_vals("hs.rst_cd");
    tick(I_NONE);
    chk("hs.post_rst_state", int'(bus.state), 0);
    chk("hs.post_rst_chg", int'(bus.state_chg), 0);
    tick(I_ST);
    chk("hs.restart_state", int'(bus.state), 1);
    chk("hs.restart_chg", int'(bus.state_chg), 1);

    // Reset in PAUSE
    go_countdown();
    wait_state(4, 4000, n);
    chk("hs.race_latency", n, 3000);
    chk("hs.race_chg", int'(bus.state_chg), 1);
    tick(I_PA);
    chk("hs.pause_state", int'(bus.state), 5);
    tick(I_RST);
    chk_reset_vals("hs.rst_pause");
    tick(I_ST);
    chk("hs.after_pause_rst_state", int'(bus.state), 1);
    chk("hs.after_pause_rst_chg", int'(bus.state_chg), 1);

    // Car 1 alone wins
    go_countdown();
    wait_state(4, 4000, n);
    chk("hs.race2_latency", n, 3000);
    tick(I_P1);
    chk("hs.p1_state", int'(bus.state), 6);
    chk("hs.p1_winner", int'(bus.winner), 1);
    tick(I_ST);
    chk("hs.p1_idle", int'(bus.state), 0);
    chk("hs.p1_cleared", int'(bus.winner), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/race_sequencer.md
Name: race_sequencer

Overview:
Top-level game-flow controller for the two-player racer. It generates the shared 3-bit state code (IDLE/SETTING/SYNCING/COUNTDOWN/RACING/PAUSE/FINISH) that drives both car physics instances. It runs the start countdown, the race timer and pause, detects the winner from the per-car finish flags, and optionally handshakes with the peer board before the countdown starts.

Parameters:
CLK_FREQ, 100_000_000, system clock in Hz; the seconds prescaler wraps at CLK_FREQ-1.
COUNT_SECONDS, 3, countdown length in seconds (1..15).
CS_DIV, CLK_FREQ/100, cycles per centisecond tick of the race timer.
MAX_TIME, 9999, race-timer saturation value in centiseconds.
SYNC_TIMEOUT_S, 5, seconds in SYNCING before giving up (only used with the optional feature).

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
start_pulse  in  1  single-cycle, debounced start/confirm button
pause_pulse  in  1  single-cycle, debounced pause button
p1_finish  in  1  level, car 1 finished
p2_finish  in  1  level, car 2 finished
peer_ready  in  1  level, peer board ready (optional feature only)
state  out  3  encoding: 0 IDLE, 1 SETTING, 2 SYNCING, 3 COUNTDOWN, 4 RACING, 5 PAUSE, 6 FINISH
countdown  out  4  seconds remaining for display
race_time  out  14  elapsed racing time in centiseconds
winner  out  2  0 none, 1 car1, 2 car2, 3 tie
sync_req  out  1  high while in SYNCING
state_chg  out  1  one-cycle pulse on any state transition

Behaviour:
- All outputs are registered. Reset values: state=0, countdown=0, race_time=0, winner=0, sync_req=0, state_chg=0. Reset also clears both prescalers. rst wins in every state, mid-countdown and mid-race included.
- Transitions take effect 1 cycle after the qualifying input. state_chg is high in the first cycle the new state is visible.
- IDLE: on start_pulse, go to SETTING. Clear race_time and winner on entry.
- SETTING: on start_pulse, go to SYNCING if the feature is enabled, otherwise to COUNTDOWN.
- COUNTDOWN: on entry, countdown=COUNT_SECONDS and the seconds prescaler is zeroed. Each prescaler wrap decrements countdown. The wrap that takes countdown from 1 to 0 enters RACING. RACING therefore starts exactly COUNT_SECONDS*CLK_FREQ cycles after COUNTDOWN is entered. Pulses are ignored in COUNTDOWN.
- RACING: the centisecond prescaler runs and race_time increments every CS_DIV cycles, saturating at MAX_TIME with no wrap.
  - Any finish flag high enters FINISH. winner=1 if only p1, 2 if only p2, 3 if both in the same cycle.
  - pause_pulse enters PAUSE. Finish has priority over pause in the same cycle.
  - start_pulse is ignored.
- PAUSE: race_time and the centisecond prescaler are frozen, not cleared. Finish flags are ignored. pause_pulse returns to RACING and counting resumes from the frozen prescaler value. start_pulse aborts to IDLE. If both pulses arrive together, pause wins.
- FINISH: race_time and winner are held. start_pulse goes to IDLE. Finish flags are ignored.
- Undefined state codes (7) recover to IDLE on the next cycle.

Optional Feature:
RACE_SYNC_HANDSHAKE_EN
- Defined: SETTING goes to SYNCING. sync_req=1 throughout SYNCING.
  - peer_ready high goes to COUNTDOWN.
  - If SYNC_TIMEOUT_S seconds elapse without peer_ready, return to SETTING.
  - start_pulse in SYNCING cancels to SETTING.
- Undefined: SYNCING is unreachable. sync_req is tied to 0 and peer_ready is unused. SETTING goes directly to COUNTDOWN.

Test Plan:
1. CLK_FREQ=1000, CS_DIV=10, feature off. Reset, then start, start. Expect state 0→1→3; countdown 3,2,1; RACING exactly 3000 cycles after COUNTDOWN entry; race_time=50 after 500 racing cycles.
2. In RACING, assert p2_finish. Expect FINISH next cycle, winner=2, race_time frozen; start_pulse returns to IDLE and clears race_time and winner.
3. In RACING, pause at race_time=20, wait 1000 cycles, pause again. Expect race_time still 20 during PAUSE; 21 within 10 cycles after resuming; p1_finish during PAUSE ignored.
4. Assert p1_finish, p2_finish and pause_pulse in the same cycle. Expect FINISH with winner=3 (PAUSE not entered); separately, MAX_TIME=30 with a long race saturates race_time at 30.
5. Feature on: start, start gives SYNCING with sync_req=1. peer_ready low for 5000 cycles returns to SETTING; peer_ready high gives COUNTDOWN next cycle with sync_req=0.
6. Assert rst at countdown=2, and again in PAUSE. Expect all outputs at reset values next cycle, and the state_chg pulse generated correctly afterwards.
